alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle controller that drives the 16-bit ALU's control and operand inputs to run operations the ALU cannot do in one pass: N-bit shifts (one bit per cycle through the ALU shift path) and 16x16 multiply, low 16 bits (shift-add). Sits between the microsequencer and the ALU. Owns the ALU only while busy; tri-states the ALU result (fyoe=0) otherwise so the result bus stays free for other drivers.

## Interface
- No parameters; data width fixed at 16.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when busy=0
- op  in  2  0=SHL, 1=SHR, 2=MUL, 3=reserved
- count  in  4  shift distance 0..15 (ignored for MUL)
- a_in, b_in  in  16  operands (SHL/SHR use a_in; MUL a_in*b_in)
- alu_a, alu_b  out  16  ALU operands
- alu_f  out  5  ALU function code
- alu_fsel, alu_csel, alu_ucin, alu_fyoe  out  1 each  ALU controls
- alu_y  in  16  ALU result; alu_cout  in  1  ALU carry out
- result  out  16  final value, held until next accepted start
- carry, zero  out  1 each  result flags, held with result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, result/flags valid

## Operation
- States: IDLE, SHIFT, MUL_ADD, MUL_SHIFT, DONE.
- IDLE + start: latch operands. SHL/SHR: acc<=a_in, cnt<=count, next SHIFT, or DONE if count=0. MUL: acc<=0, mcand<=a_in, mplier<=b_in, i<=16, csticky<=0, next MUL_ADD. op=3: acc<=a_in, next DONE.
- SHIFT: alu_a=acc, fsel=SHIFT, f=SHIFT_LEFT/RIGHT, fyoe=1. Edge: acc<=alu_y, cshift<=bit shifted out (acc[15] for SHL, acc[0] for SHR, taken internally), cnt<=cnt-1. Exit to DONE after the edge where cnt reaches 0.
- MUL_ADD: alu_a=acc, alu_b=mcand, fsel=74181, csel=UCIN, ucin=0, fyoe=1; f=ADD if mplier[0] else F_A (pass acc, no carry). Edge: acc<=alu_y; csticky|=alu_cout when adding. Next MUL_SHIFT.
- MUL_SHIFT: alu_a=mcand, SHIFT_LEFT. Edge: mcand<=alu_y, mplier<=mplier>>1, i<=i-1; next DONE if i reaches 0, else MUL_ADD.
- On the edge entering DONE: result<=acc; zero<=(acc==0) by internal compare, not ALU zout; carry<=last shifted-out bit (SHL/SHR), csticky (MUL), 0 (count=0, op=3).
- MUL carry flags only add-overflow; bits lost from mcand shifts are not flagged.
- DONE: done=1, fyoe=0, next IDLE unconditionally.
- In IDLE/DONE: alu_fyoe=0, alu_a=alu_b=0, f/fsel/csel/ucin=0.

## Timing
- Reset: state IDLE; result=0, carry=0, zero=0, busy=0, done=0, alu_fyoe=0, all internal registers 0. Reset mid-operation aborts; no done pulse.
- Start accepted at edge E0; busy high from E0+1.
- SHL/SHR count n>0: shift edges E1..En, done high in cycle after En (start to done = n+1 cycles). n=0: done in cycle after E0.
- MUL: 32 ALU cycles, done in cycle after E32; constant regardless of operand values.
- start while busy, including during DONE: ignored, no queuing. start is accepted in the cycle after done.
- reset wins over start in the same cycle.
- ALU is combinational; alu_y is sampled in the same cycle its controls are driven.

## Structure
- ALU control codes (ALU_F_*, ALU_FSEL_*, ALU_CSEL_*) come from the shared globals header. Add SEQ_OP_SHL/SHR/MUL there.
- State encodings stay local to the module.
- No sub-module; the ALU is instantiated beside this block, and the bench instantiates both.

## Test plan
- SHL a_in=0x0003, count=4: result=0x0030, carry=0, zero=0; done 5 cycles after start edge; alu_fyoe=1 for exactly 4 cycles.
- SHR a_in=0xF031, count=1: result=0x7818, carry=1; done 2 cycles after start.
- MUL 0x00FF*0x0101: result=0xFFFF, carry=0, zero=0; done 33 cycles after start.
- MUL 0xFFFF*0x0003: result=0xFFFD, carry=1. MUL 0x0100*0x0100: result=0x0000, zero=1, carry=0.
- SHL count=0 a_in=0xBEEF: result=0xBEEF, carry=0, done 1 cycle after start. op=3 gives the same result.
- MUL started, reset at cycle 10: next cycle busy=0, result=0, alu_fyoe=0, no done pulse. start pulsed while busy: ignored, original result unchanged.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared ALU control codes and the sequencer's operation codes.
package alu_sequencer_pkg;
    localparam logic [4:0] ALU_F_A           = 5'h00;
    localparam logic [4:0] ALU_F_SHIFT_LEFT  = 5'h01;
    localparam logic [4:0] ALU_F_SHIFT_RIGHT = 5'h02;
    localparam logic [4:0] ALU_F_ADD         = 5'h09;
    localparam logic       ALU_FSEL_74181    = 1'b0;
    localparam logic       ALU_FSEL_SHIFT    = 1'b1;
    localparam logic       ALU_CSEL_UCIN     = 1'b1;
    localparam logic [1:0] SEQ_OP_SHL        = 2'd0;
    localparam logic [1:0] SEQ_OP_SHR        = 2'd1;
    localparam logic [1:0] SEQ_OP_MUL        = 2'd2;
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the external 16-bit ALU through multi-cycle shifts and shift-add multiply.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  count,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_fsel,
    output logic        alu_csel,
    output logic        alu_ucin,
    output logic        alu_fyoe,
    input  logic [15:0] alu_y,
    input  logic        alu_cout,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, SHIFT, MUL_ADD, MUL_SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  i_q, i_d;
    logic        csticky_q, csticky_d, carry_q, carry_d, zero_q, zero_d, last_c;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        csticky_d = csticky_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        last_c    = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_f     = ALU_F_A;
        alu_fsel  = 1'b0;
        alu_csel  = 1'b0;
        alu_ucin  = 1'b0;
        alu_fyoe  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                op_d  = op;
                acc_d = a_in;
                cnt_d = count;
                if (op == SEQ_OP_MUL) begin
                    acc_d     = '0;
                    mcand_d   = a_in;
                    mplier_d  = b_in;
                    i_d       = 5'd16;
                    csticky_d = 1'b0;
                    state_d   = MUL_ADD;
                end else begin
                    state_d = (op == SEQ_OP_SHL || op == SEQ_OP_SHR) && count != 4'd0 ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                alu_a    = acc_q;
                alu_fsel = ALU_FSEL_SHIFT;
                alu_fyoe = 1'b1;
                alu_f    = op_q == SEQ_OP_SHL ? ALU_F_SHIFT_LEFT : ALU_F_SHIFT_RIGHT;
                acc_d    = alu_y;
                last_c   = op_q == SEQ_OP_SHL ? acc_q[15] : acc_q[0];
                cnt_d    = cnt_q - 4'd1;
                state_d  = cnt_q == 4'd1 ? DONE : SHIFT;
            end
            MUL_ADD: begin
                alu_a     = acc_q;
                alu_b     = mcand_q;
                alu_fsel  = ALU_FSEL_74181;
                alu_csel  = ALU_CSEL_UCIN;
                alu_fyoe  = 1'b1;
                alu_f     = mplier_q[0] ? ALU_F_ADD : ALU_F_A;
                acc_d     = alu_y;
                csticky_d = csticky_q | (mplier_q[0] & alu_cout);
                state_d   = MUL_SHIFT;
            end
            MUL_SHIFT: begin
                alu_a    = mcand_q;
                alu_fsel = ALU_FSEL_SHIFT;
                alu_f    = ALU_F_SHIFT_LEFT;
                alu_fyoe = 1'b1;
                mcand_d  = alu_y;
                mplier_d = mplier_q >> 1;
                i_d      = i_q - 5'd1;
                last_c   = csticky_q;
                state_d  = i_q == 5'd1 ? DONE : MUL_ADD;
            end
            default: state_d = IDLE;
        endcase
        // Flags are captured from the value acc takes on the same edge, not from the ALU zero output.
        if (state_d == DONE) begin
            result_d = acc_d;
            zero_d   = acc_d == 16'd0;
            carry_d  = last_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            i_q       <= '0;
            csticky_q <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            csticky_q <= csticky_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: bench with a behavioural ALU, a spec-level model checked every cycle, and directed literal cases.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0]  op = '0;
    logic [3:0]  count = '0;
    logic [15:0] a_in = '0, b_in = '0;
    logic [15:0] alu_a, alu_b, alu_y, result;
    logic [4:0]  alu_f;
    logic        alu_fsel, alu_csel, alu_ucin, alu_fyoe, alu_cout, carry, zero, busy, done;
    int          checks = 0, errors = 0, fy_cnt = 0;
    logic        chk_en = 1'b0;
    logic        m_busy = 1'b0, m_c = 1'b0, m_z = 1'b0, e_c;
    logic [15:0] m_res = '0, e_res;
    int          m_cyc = 0, m_lat = 1;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .count(count), .a_in(a_in), .b_in(b_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_fsel(alu_fsel), .alu_csel(alu_csel),
        .alu_ucin(alu_ucin), .alu_fyoe(alu_fyoe), .alu_y(alu_y), .alu_cout(alu_cout),
        .result(result), .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    // Combinational ALU standing in for the real one
    always_comb begin
        alu_y    = '0;
        alu_cout = 1'b0;
        if (alu_fsel == ALU_FSEL_SHIFT) begin
            alu_y    = alu_f == ALU_F_SHIFT_LEFT ? {alu_a[14:0], 1'b0} : {1'b0, alu_a[15:1]};
            alu_cout = alu_f == ALU_F_SHIFT_LEFT ? alu_a[15] : alu_a[0];
        end else if (alu_f == ALU_F_ADD) begin
            {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_csel & alu_ucin};
        end else if (alu_f == ALU_F_A) begin
            alu_y = alu_a;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_calc(input logic [1:0] o, input int n, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [16:0] s;
        logic [15:0] acc, sh;
        e_c = 1'b0;
        if (o == SEQ_OP_SHL) begin
            e_res = a << n;
            if (n > 0) e_c = a[16-n];
            m_lat = n + 1;
        end else if (o == SEQ_OP_SHR) begin
            e_res = a >> n;
            if (n > 0) e_c = a[n-1];
            m_lat = n + 1;
        end else if (o == SEQ_OP_MUL) begin
            p     = {16'd0, a} * {16'd0, b};
            e_res = p[15:0];
            acc   = '0;
            for (int k = 0; k < 16; k++) begin
                if (b[k]) begin
                    sh  = a << k;
                    s   = {1'b0, acc} + {1'b0, sh};
                    e_c = e_c | s[16];
                    acc = s[15:0];
                end
            end
            m_lat = 33;
        end else begin
            e_res = a;
            m_lat = 1;
        end
    endtask

    task automatic publish();
        m_res = e_res;
        m_c   = e_c;
        m_z   = e_res == 16'd0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_cyc  = 0;
            m_res  = '0;
            m_c    = 1'b0;
            m_z    = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                model_calc(op, int'(count), a_in, b_in);
                m_busy = 1'b1;
                m_cyc  = 1;
                if (m_lat == 1) publish();
            end
        end else if (m_cyc == m_lat) begin
            m_busy = 1'b0;
        end else begin
            m_cyc++;
            if (m_cyc == m_lat) publish();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 16'(busy), 16'(m_busy));
            chk("done", 16'(done), 16'(m_busy && m_cyc == m_lat));
            chk("fyoe", 16'(alu_fyoe), 16'(m_busy && m_cyc < m_lat));
            chk("result", result, m_res);
            chk("carry", 16'(carry), 16'(m_c));
            chk("zero", 16'(zero), 16'(m_z));
        end
    end

    task automatic run(input logic [1:0] o, input logic [3:0] n, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] xr, input logic xc, input logic xz, input int xlat, input int poke);
        int k = 0;
        fy_cnt = 0;
        op = o; count = n; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (alu_fyoe) fy_cnt++;
            if (k == poke) begin
                op = SEQ_OP_SHL; count = 4'd0; a_in = 16'h1234; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end while (!done && k < 60);
        start = 1'b0;
        chk("lat", 16'(k), 16'(xlat));
        chk("lit_result", result, xr);
        chk("lit_carry", 16'(carry), 16'(xc));
        chk("lit_zero", 16'(zero), 16'(xz));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic saw;
        int k;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_result", result, 16'd0);
        chk("rst_fyoe", 16'(alu_fyoe), 16'd0);
        @(posedge clk);
        #1;
        run(SEQ_OP_SHL, 4'd4, 16'h0003, 16'h0, 16'h0030, 1'b0, 1'b0, 5, 0);
        chk("shl_fyoe_cnt", 16'(fy_cnt), 16'd4);
        run(SEQ_OP_SHR, 4'd1, 16'hF031, 16'h0, 16'h7818, 1'b1, 1'b0, 2, 0);
        run(SEQ_OP_MUL, 4'd0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 33, 0);
        run(SEQ_OP_MUL, 4'd7, 16'hFFFF, 16'h0003, 16'hFFFD, 1'b1, 1'b0, 33, 0);
        run(SEQ_OP_MUL, 4'd0, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 33, 0);
        run(SEQ_OP_SHL, 4'd0, 16'hBEEF, 16'h0, 16'hBEEF, 1'b0, 1'b0, 1, 0);
        run(2'd3, 4'd5, 16'hBEEF, 16'h0, 16'hBEEF, 1'b0, 1'b0, 1, 0);
        run(SEQ_OP_SHL, 4'd15, 16'h0003, 16'h0, 16'h8000, 1'b1, 1'b0, 16, 0);
        run(SEQ_OP_SHR, 4'd15, 16'h8001, 16'h0, 16'h0001, 1'b0, 1'b0, 16, 0);
        run(SEQ_OP_MUL, 4'd0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 33, 5);
        // start held through DONE is ignored there and accepted the cycle after
        op = SEQ_OP_SHR; count = 4'd1; a_in = 16'hF031; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 60);
        chk("dn_lat", 16'(k), 16'd2);
        op = SEQ_OP_SHL; count = 4'd0; a_in = 16'hBEEF; start = 1'b1;
        @(posedge clk);
        #1 chk("dn_ignored_busy", 16'(busy), 16'd0);
        chk("dn_ignored_result", result, 16'h7818);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("dn_accept_done", 16'(done), 16'd1);
        chk("dn_accept_result", result, 16'hBEEF);
        @(posedge clk);
        #1;
        // reset in the middle of a multiply
        op = SEQ_OP_MUL; a_in = 16'h1234; b_in = 16'h0007; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_result", result, 16'd0);
        chk("mid_rst_fyoe", 16'(alu_fyoe), 16'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("mid_rst_no_done", 16'(saw), 16'd0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
